mcu_trace_fifo: RTL and testbench

MCU_TRACE_FIFO -- requirements
Module: mcu_trace_fifo

---
 rtl/mcu_trace_pkg.sv | 19 +
 rtl/trace_fifo_mem.sv | 65 ++++++
 rtl/mcu_trace_fifo.sv | 117 +++++++++++
 tb/tb_mcu_trace_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_trace_pkg.sv
// Shared types and constants for the MCU instruction trace FIFO.
package mcu_trace_pkg;

    typedef struct packed {
        logic [7:0] pc;
        logic [3:0] opcode;
        logic [7:0] alu;
        logic [7:0] wreg;
    } trace_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StHalted
    } trace_state_t;

    localparam logic [7:0] DefaultHaltPc = 8'h14;

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace entry storage: circular buffer with read/write pointers and an occupancy count.
// Read side is first-word-fall-through; rd_data is zero while empty.
module trace_fifo_mem
    import mcu_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  trace_entry_t             wr_data,
    input  logic                     rd_en,
    output trace_entry_t             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = DEPTH[PtrW:0];

    trace_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            do_wr;
    logic            do_rd;

    assign empty = (count_q == '0);
    assign full  = (count_q == FullCount);
    assign count = count_q;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a write alongside it.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mcu_trace_fifo.sv
// MCU trace capture: arm/capture/halt FSM feeding a FWFT trace FIFO with sticky overflow.
// Define TRACE_OVF_CNT_EN to add the saturating dropped-write counter output ovf_cnt.
module mcu_trace_fifo
    import mcu_trace_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter logic [7:0]  HALT_PC = DefaultHaltPc
) (
    input  logic                   clk,
    input  logic                   SWO,
    input  logic                   arm,
    input  logic                   cap_en,
    input  logic [7:0]             pc_in,
    input  logic [3:0]             opcode_in,
    input  logic [7:0]             alu_in,
    input  logic [7:0]             wreg_in,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [27:0]            rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   halted,
`ifdef TRACE_OVF_CNT_EN
    output logic [7:0]             ovf_cnt,
`endif
    output logic                   overflow
);

    trace_state_t state_q;
    trace_entry_t wr_entry;
    trace_entry_t rd_entry;
    logic         wr_req;
    logic         rd_req;
    logic         drop;
    logic         halted_q;
    logic         overflow_q;

    assign wr_entry = '{pc: pc_in, opcode: opcode_in, alu: alu_in, wreg: wreg_in};
    assign wr_req   = (state_q == StCapture) && cap_en;
    assign rd_req   = rd_valid && rd_ready;
    assign drop     = wr_req && full && !rd_req;

    trace_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (SWO),
        .wr_en   (wr_req),
        .wr_data (wr_entry),
        .rd_en   (rd_req),
        .rd_data (rd_entry),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign rd_valid = !empty;
    assign rd_data  = rd_entry;
    assign halted   = halted_q;
    assign overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (SWO) begin
            state_q  <= StIdle;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arm) begin
                        state_q <= StCapture;
                    end
                end
                StCapture: begin
                    // The halting instruction is still captured; capture stops after it.
                    if (cap_en && (pc_in == HALT_PC)) begin
                        state_q  <= StHalted;
                        halted_q <= 1'b1;
                    end
                end
                StHalted: begin
                    if (arm) begin
                        state_q  <= StCapture;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (SWO) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

`ifdef TRACE_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;

    assign ovf_cnt = ovf_cnt_q;

    always_ff @(posedge clk) begin
        if (SWO) begin
            ovf_cnt_q <= '0;
        end else if (drop && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mcu_trace_fifo.sv
// Directed self-checking bench for mcu_trace_fifo (DEPTH=8, HALT_PC=8'h14).
module tb_mcu_trace_fifo;

    logic        clk = 1'b0;
    logic        SWO;
    logic        arm;
    logic        cap_en;
    logic [7:0]  pc_in;
    logic [3:0]  opcode_in;
    logic [7:0]  alu_in;
    logic [7:0]  wreg_in;
    logic        rd_ready;
    logic        rd_valid;
    logic [27:0] rd_data;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        halted;
    logic        overflow;
`ifdef TRACE_OVF_CNT_EN
    logic [7:0]  ovf_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mcu_trace_fifo #(
        .DEPTH   (8),
        .HALT_PC (8'h14)
    ) dut (
        .clk       (clk),
        .SWO       (SWO),
        .arm       (arm),
        .cap_en    (cap_en),
        .pc_in     (pc_in),
        .opcode_in (opcode_in),
        .alu_in    (alu_in),
        .wreg_in   (wreg_in),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .halted    (halted),
`ifdef TRACE_OVF_CNT_EN
        .ovf_cnt   (ovf_cnt),
`endif
        .overflow  (overflow)
    );

    // Entry fields derived from pc so every field of a popped entry is checkable.
    function automatic logic [27:0] mk(input logic [7:0] p);
        logic [7:0] a;
        logic [7:0] w;
        a = ~p;
        w = p + 8'h11;
        return {p, p[3:0], a, w};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [7:0] p);
        logic [27:0] e;
        e         = mk(p);
        cap_en    = en;
        pc_in     = e[27:20];
        opcode_in = e[19:16];
        alu_in    = e[15:8];
        wreg_in   = e[7:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        SWO = 1'b1; arm = 1'b0; rd_ready = 1'b0;
        drive(1'b0, 8'h00);
        tick();
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
`ifdef TRACE_OVF_CNT_EN
        check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
`endif

        // IDLE ignores captures
        SWO = 1'b0;
        drive(1'b1, 8'h05);
        tick();
        check("idle_no_write", 32'(count), 32'd0);

        // Arm and capture pc 0,1,2
        drive(1'b0, 8'h00);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(i));
            tick();
        end
        drive(1'b0, 8'h00);
        check("cap3_count", 32'(count), 32'd3);
        check("cap3_rd_valid", 32'(rd_valid), 32'd1);
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("cap3_pop_data", 32'(rd_data), 32'(mk(8'(i))));
            tick();
        end
        rd_ready = 1'b0;
        check("cap3_empty", 32'(empty), 32'd1);
        check("cap3_count0", 32'(count), 32'd0);

        // Halt on pc 0x14; 0x15 not stored
        drive(1'b1, 8'h12); tick();
        drive(1'b1, 8'h13); tick();
        drive(1'b1, 8'h14); tick();
        check("halt_flag", 32'(halted), 32'd1);
        drive(1'b1, 8'h15); tick();
        check("halt_count", 32'(count), 32'd3);
        check("halt_still", 32'(halted), 32'd1);
        drive(1'b0, 8'h00);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("rearm_halted", 32'(halted), 32'd0);
        check("rearm_kept", 32'(count), 32'd3);
        drive(1'b1, 8'h20); tick();
        drive(1'b0, 8'h00);
        check("rearm_count", 32'(count), 32'd4);
        rd_ready = 1'b1;
        check("halt_pop0", 32'(rd_data), 32'(mk(8'h12))); tick();
        check("halt_pop1", 32'(rd_data), 32'(mk(8'h13))); tick();
        check("halt_pop2", 32'(rd_data), 32'(mk(8'h14))); tick();
        check("halt_pop3", 32'(rd_data), 32'(mk(8'h20))); tick();
        rd_ready = 1'b0;
        check("halt_empty", 32'(empty), 32'd1);

        // Fill to 8, then simultaneous write+pop when full
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(8'h30 + i));
            tick();
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd8);
        check("fill_no_ovf", 32'(overflow), 32'd0);
        rd_ready = 1'b1;
        drive(1'b1, 8'h38);
        tick();
        rd_ready = 1'b0;
        check("wrpop_count", 32'(count), 32'd8);
        check("wrpop_no_ovf", 32'(overflow), 32'd0);
        check("wrpop_head", 32'(rd_data), 32'(mk(8'h31)));

        // Two drops while full
        drive(1'b1, 8'h39); tick();
        drive(1'b1, 8'h3A); tick();
        drive(1'b0, 8'h00);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd8);
`ifdef TRACE_OVF_CNT_EN
        check("ovf_cnt", 32'(ovf_cnt), 32'd2);
`endif
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("ovf_pop_data", 32'(rd_data), 32'(mk(8'(8'h31 + i))));
            tick();
        end
        check("ovf_drained", 32'(empty), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Empty FIFO: pop+write same cycle, then read past empty
        drive(1'b1, 8'h50);
        tick();
        drive(1'b0, 8'h00);
        check("empty_wr_valid", 32'(rd_valid), 32'd1);
        check("empty_wr_count", 32'(count), 32'd1);
        check("empty_wr_data", 32'(rd_data), 32'(mk(8'h50)));
        tick();
        check("pop_last", 32'(count), 32'd0);
        tick();
        check("no_underflow", 32'(count), 32'd0);
        rd_ready = 1'b0;

        // Reset mid-run with 5 entries and all inputs active
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(8'h60 + i));
            tick();
        end
        check("pre_rst_count", 32'(count), 32'd5);
        SWO = 1'b1; arm = 1'b1; rd_ready = 1'b1;
        drive(1'b1, 8'h65);
        tick();
        SWO = 1'b0; arm = 1'b0; rd_ready = 1'b0;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_rd_valid", 32'(rd_valid), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
`ifdef TRACE_OVF_CNT_EN
        check("midrst_ovf_cnt", 32'(ovf_cnt), 32'd0);
`endif
        drive(1'b1, 8'h70);
        tick();
        check("midrst_idle", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
